// File: rtl/uart_fifo.sv
// Single-clock UART TX/RX buffer holding up to DEPTH-1 words, with watermark compare flags.
// Optional sticky overflow/underflow outputs are enabled by defining UART_FIFO_ERROR_FLAGS_EN.
module uart_fifo #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned DEPTH     = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   watermark_level,
   input  logic [DATA_SIZE-1:0]       wr_data,
   output logic [DATA_SIZE-1:0]       rd_data,
   output logic                       less_than_watermark,
   output logic                       greater_than_watermark,
   output logic                       empty,
   output logic                       full,
`ifdef UART_FIFO_ERROR_FLAGS_EN
   output logic                       overflow,
   output logic                       underflow,
`endif
   output logic [$clog2(DEPTH)-1:0]   watermark_reg_db
);

   localparam int unsigned    AW         = $clog2(DEPTH);
   localparam logic [AW-1:0]  ONE        = AW'(1);
   localparam logic [AW-1:0]  FULL_COUNT = AW'(DEPTH - 1);

   logic [DATA_SIZE-1:0] fifo_memory [DEPTH];
   logic [AW-1:0]        wr_reg;
   logic [AW-1:0]        rd_reg;
   logic [AW-1:0]        watermark_reg;

   logic                 w_push;
   logic                 w_pop;
   logic [AW-1:0]        w_rd_next;

   // Accept decisions use the pre-edge flags, so a pop never frees room for a same-cycle push.
   assign w_push    = wr_en & ~full;
   assign w_pop     = rd_en & ~empty;
   assign w_rd_next = rd_reg + ONE;

   assign empty                  = (watermark_reg == '0);
   assign full                   = (watermark_reg == FULL_COUNT);
   assign less_than_watermark    = (watermark_reg < watermark_level);
   assign greater_than_watermark = (watermark_reg > watermark_level);
   assign watermark_reg_db       = watermark_reg;

   always_ff @(posedge clock) begin
      if (w_push) begin
         fifo_memory[wr_reg] <= wr_data;
      end
   end

   // rd_reg points at the last popped slot, hence the all-ones reset value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_reg        <= '0;
         rd_reg        <= '1;
         watermark_reg <= '0;
         rd_data       <= '0;
      end else begin
         if (w_push) begin
            wr_reg <= wr_reg + ONE;
         end
         if (w_pop) begin
            rd_reg  <= w_rd_next;
            rd_data <= fifo_memory[w_rd_next];
         end
         case ({w_push, w_pop})
            2'b10:   watermark_reg <= watermark_reg + ONE;
            2'b01:   watermark_reg <= watermark_reg - ONE;
            default: watermark_reg <= watermark_reg;
         endcase
      end
   end

`ifdef UART_FIFO_ERROR_FLAGS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: queue scoreboard model, flag table, corner sequences, soak.
// Covers UART_FIFO_ERROR_FLAGS_EN outputs when that macro is defined.
module tb_uart_fifo;

   localparam int unsigned DATA_SIZE = 32;
   localparam int unsigned DEPTH     = 8;
   localparam int unsigned AW        = $clog2(DEPTH);

   logic                 clock;
   logic                 reset;
   logic                 wr_en;
   logic                 rd_en;
   logic [AW-1:0]        watermark_level;
   logic [DATA_SIZE-1:0] wr_data;
   logic [DATA_SIZE-1:0] rd_data;
   logic                 less_than_watermark;
   logic                 greater_than_watermark;
   logic                 empty;
   logic                 full;
   logic [AW-1:0]        watermark_reg_db;
`ifdef UART_FIFO_ERROR_FLAGS_EN
   logic                 overflow;
   logic                 underflow;
`endif

   uart_fifo #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .wr_en                  (wr_en),
      .rd_en                  (rd_en),
      .watermark_level        (watermark_level),
      .wr_data                (wr_data),
      .rd_data                (rd_data),
      .less_than_watermark    (less_than_watermark),
      .greater_than_watermark (greater_than_watermark),
      .empty                  (empty),
      .full                   (full),
`ifdef UART_FIFO_ERROR_FLAGS_EN
      .overflow               (overflow),
      .underflow              (underflow),
`endif
      .watermark_reg_db       (watermark_reg_db)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents as a queue, plus the last popped word.
   logic [DATA_SIZE-1:0] model_q [$];
   logic [DATA_SIZE-1:0] model_rd;
   logic                 model_ovf;
   logic                 model_udf;

   typedef struct {
      int unsigned count;
      logic        exp_empty;
      logic        exp_full;
      logic        exp_less;
      logic        exp_greater;
   } flag_vec_t;

   flag_vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      int unsigned cnt;
      cnt = model_q.size();
      check({tag, " count"}, 64'(watermark_reg_db), 64'(cnt));
      check({tag, " empty"}, 64'(empty), 64'(cnt == 0));
      check({tag, " full"}, 64'(full), 64'(cnt == DEPTH - 1));
      check({tag, " less"}, 64'(less_than_watermark), 64'(cnt < 32'(watermark_level)));
      check({tag, " greater"}, 64'(greater_than_watermark), 64'(cnt > 32'(watermark_level)));
      check({tag, " rd_data"}, 64'(rd_data), 64'(model_rd));
`ifdef UART_FIFO_ERROR_FLAGS_EN
      check({tag, " overflow"}, 64'(overflow), 64'(model_ovf));
      check({tag, " underflow"}, 64'(underflow), 64'(model_udf));
`endif
   endtask

   // Called just after an active edge; drives one cycle, updates the model, checks state.
   task automatic do_cycle(input logic wr, input logic rd, input logic [DATA_SIZE-1:0] data,
                           input string tag);
      bit push_ok;
      bit pop_ok;
      push_ok = wr && (model_q.size() < DEPTH - 1);
      pop_ok  = rd && (model_q.size() > 0);
      if (wr && !push_ok) model_ovf = 1'b1;
      if (rd && !pop_ok)  model_udf = 1'b1;
      wr_en   = wr;
      rd_en   = rd;
      wr_data = data;
      @(posedge clock);
      #1;
      if (pop_ok)  model_rd = model_q.pop_front();
      if (push_ok) model_q.push_back(data);
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_state(tag);
   endtask

   task automatic model_reset();
      model_q.delete();
      model_rd  = '0;
      model_ovf = 1'b0;
      model_udf = 1'b0;
   endtask

   initial begin
      vecs[0] = '{0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{2, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{3, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{4, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{5, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{6, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{7, 1'b0, 1'b1, 1'b0, 1'b1};

      reset           = 1'b1;
      wr_en           = 1'b0;
      rd_en           = 1'b0;
      wr_data         = '0;
      watermark_level = 3'd3;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state, independent of the model
      check("reset count", 64'(watermark_reg_db), 64'd0);
      check("reset empty", 64'(empty), 64'd1);
      check("reset full", 64'(full), 64'd0);
      check("reset rd_data", 64'(rd_data), 64'd0);
      check("reset less", 64'(less_than_watermark), 64'd1);
      check("reset greater", 64'(greater_than_watermark), 64'd0);

      // Fill 0xA0..0xA6 while walking the watermark flag table at level 4
      watermark_level = 3'd4;
      #1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tbl%0d count", i), 64'(watermark_reg_db), 64'(vecs[i].count));
         check($sformatf("tbl%0d empty", i), 64'(empty), 64'(vecs[i].exp_empty));
         check($sformatf("tbl%0d full", i), 64'(full), 64'(vecs[i].exp_full));
         check($sformatf("tbl%0d less", i), 64'(less_than_watermark), 64'(vecs[i].exp_less));
         check($sformatf("tbl%0d greater", i), 64'(greater_than_watermark),
               64'(vecs[i].exp_greater));
         if (i < 7) do_cycle(1'b1, 1'b0, 32'hA0 + 32'(i), "fill");
      end

      do_cycle(1'b1, 1'b0, 32'hA7, "push_full");
      check("push_full count", 64'(watermark_reg_db), 64'd7);

      for (int i = 0; i < 7; i++) begin
         do_cycle(1'b0, 1'b1, '0, "drain");
         check($sformatf("drain%0d data", i), 64'(rd_data), 64'hA0 + 64'(i));
      end
      check("drained empty", 64'(empty), 64'd1);
      do_cycle(1'b0, 1'b1, '0, "pop_empty");
      check("pop_empty rd_data", 64'(rd_data), 64'hA6);

      // Simultaneous push+pop at count 3; 0x55 must come out after B1, B2
      do_cycle(1'b1, 1'b0, 32'hB0, "sim_fill");
      do_cycle(1'b1, 1'b0, 32'hB1, "sim_fill");
      do_cycle(1'b1, 1'b0, 32'hB2, "sim_fill");
      do_cycle(1'b1, 1'b1, 32'h55, "sim_both");
      check("sim_both count", 64'(watermark_reg_db), 64'd3);
      check("sim_both rd_data", 64'(rd_data), 64'hB0);
      do_cycle(1'b0, 1'b1, '0, "sim_drain");
      do_cycle(1'b0, 1'b1, '0, "sim_drain");
      do_cycle(1'b0, 1'b1, '0, "sim_drain");
      check("sim_55 out", 64'(rd_data), 64'h55);

      // Both asserted when full: push rejected
      for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 32'hC0 + 32'(i), "full_fill");
      do_cycle(1'b1, 1'b1, 32'hEE, "full_both");
      check("full_both count", 64'(watermark_reg_db), 64'd6);
      check("full_both rd_data", 64'(rd_data), 64'hC0);
      for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, '0, "full_drain");
      check("full_drain last", 64'(rd_data), 64'hC6);

      // Both asserted when empty: pop rejected
      do_cycle(1'b1, 1'b1, 32'hD1, "empty_both");
      check("empty_both count", 64'(watermark_reg_db), 64'd1);
      check("empty_both rd_data", 64'(rd_data), 64'hC6);
      do_cycle(1'b0, 1'b1, '0, "empty_drain");
      check("empty_drain data", 64'(rd_data), 64'hD1);

      // Asynchronous reset mid-cycle discards contents without waiting for an edge
      do_cycle(1'b1, 1'b0, 32'hF0, "pre_rst");
      do_cycle(1'b1, 1'b0, 32'hF1, "pre_rst");
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("async_rst count", 64'(watermark_reg_db), 64'd0);
      check("async_rst empty", 64'(empty), 64'd1);
      check("async_rst rd_data", 64'(rd_data), 64'd0);
`ifdef UART_FIFO_ERROR_FLAGS_EN
      check("async_rst overflow", 64'(overflow), 64'd0);
      check("async_rst underflow", 64'(underflow), 64'd0);
`endif
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_state("post_rst");

      // Random soak with varying watermark level; bias toward exercising full and empty
      for (int i = 0; i < 1000; i++) begin
         logic wr;
         logic rd;
         int   phase;
         phase = (i / 100) % 2;
         wr = ($urandom_range(99) < (phase == 0 ? 70 : 35));
         rd = ($urandom_range(99) < (phase == 0 ? 35 : 70));
         watermark_level = AW'($urandom_range(DEPTH - 1));
         do_cycle(wr, rd, $urandom, "soak");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Synchronous single-clock FIFO used as the TX/RX buffer of the UART peripheral.
- Stores up to DEPTH-1 words.
- Exposes empty/full flags and two comparison flags against a programmable watermark level.
- Exposes its internal occupancy count as a debug port.

Parameters:
DATA_SIZE, 32, width of each stored word in bits
DEPTH, 8, number of memory entries; power of two, at least 4; usable capacity is DEPTH-1

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  push request
rd_en  input  1  pop request
watermark_level  input  $clog2(DEPTH)  threshold compared against occupancy
wr_data  input  DATA_SIZE  word to push
rd_data  output  DATA_SIZE  most recently popped word
less_than_watermark  output  1  occupancy < watermark_level
greater_than_watermark  output  1  occupancy > watermark_level
empty  output  1  occupancy == 0
full  output  1  occupancy == DEPTH-1
watermark_reg_db  output  $clog2(DEPTH)  debug copy of the occupancy register

Behaviour:
- Interface: one clock, named clock. Reset is asynchronous and active-high, named reset.
- State registers:
  - memory array fifo_memory[DEPTH], not reset.
  - write pointer wr_reg, $clog2(DEPTH) bits.
  - read pointer rd_reg, $clog2(DEPTH) bits; holds the index of the last popped entry.
  - occupancy watermark_reg, $clog2(DEPTH) bits.
  - rd_data register.
- Reset values (asynchronous): wr_reg=0, rd_reg=all ones (DEPTH-1), watermark_reg=0, rd_data=0.
  - Resulting flags: empty=1, full=0.
  - Reset asserted mid-operation discards all contents immediately.
- Push accepted when wr_en=1 and full=0 (flag value before the edge).
  - On accept: fifo_memory[wr_reg] <= wr_data; wr_reg <= wr_reg+1.
  - Push while full is ignored: no state change, no error.
- Pop accepted when rd_en=1 and empty=0 (flag value before the edge).
  - On accept: rd_reg <= rd_reg+1; rd_data <= fifo_memory[rd_reg+1].
  - rd_data therefore equals fifo_memory[rd_reg] one cycle after the pop.
  - Pop while empty is ignored; rd_data holds its value.
- Occupancy update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Simultaneous push and pop:
  - Both are evaluated against pre-edge flags.
  - When full, push is rejected even if a pop is accepted.
  - When empty, pop is rejected even if a push is accepted.
- Pointers wrap modulo DEPTH (natural binary overflow).
- Flags are combinational from watermark_reg and watermark_level, valid in the same cycle the register changes:
  - empty = (watermark_reg==0)
  - full = (watermark_reg==DEPTH-1)
  - less_than_watermark = (watermark_reg < watermark_level), unsigned
  - greater_than_watermark = (watermark_reg > watermark_level), unsigned
- Latency: a pushed word is poppable on the next cycle; empty deasserts one edge after the first push.
- watermark_reg_db = watermark_reg, continuously.

Optional Feature:
- Macro: UART_FIFO_ERROR_FLAGS_EN.
- When defined, two extra 1-bit outputs are added:
  - overflow: set on wr_en=1 while full=1.
  - underflow: set on rd_en=1 while empty=1.
  - Both are sticky and cleared only by reset (reset value 0).
  - Rejected operations still cause no other state change.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: assert reset, release.
  - Expect wr_reg=0, rd_reg=7, watermark_reg_db=0, empty=1, full=0, rd_data=0.
  - With watermark_level=3: less=1, greater=0.
- Fill to full: push 0xA0..0xA6 (7 writes) with rd_en=0.
  - After the 7th edge: full=1, watermark_reg_db=7.
  - 8th push of 0xA7: wr_reg stays 7, count stays 7, memory unchanged.
- Drain: pop 7 times.
  - rd_data sequence 0xA0..0xA6, one per cycle after each pop.
  - Then empty=1. An 8th pop leaves rd_data=0xA6 and rd_reg unchanged.
- Simultaneous push+pop:
  - With count=3, push 0x55 and pop in one cycle: count stays 3, rd_data = oldest word, 0x55 stored at old wr_reg.
  - When full with both asserted: count drops to 6 (push rejected).
  - When empty with both asserted: count becomes 1 (pop rejected).
- Watermark flags: watermark_level=4, step count 0..7.
  - less=1 for counts 0–3; less=0 and greater=0 at count 4; greater=1 for counts 5–7.
- Random soak: 1000 cycles of random wr_en/rd_en/wr_data against a reference model.
  - Pointers, count, rd_data and all four flags match every cycle, including wrap-around.
